// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, hazard-controller state and the latch control bundle.
// Control constants are one per priority outcome so the top's priority block stays readable.
package cpu_types_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {HZ_RUN, HZ_DWAIT, HZ_HALT} hzd_state_t;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_en;
      logic idex_flush;
      logic exmem_en;
      logic exmem_flush;
      logic memwb_en;
   } hzd_ctrl_t;

   localparam hzd_ctrl_t CTRL_IDLE = '0;
   localparam hzd_ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                      idex_en: 1'b1, idex_flush: 1'b0,
                                      exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1};
   localparam hzd_ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                         idex_en: 1'b1, idex_flush: 1'b1,
                                         exmem_en: 1'b1, exmem_flush: 1'b1, memwb_en: 1'b1};
   localparam hzd_ctrl_t CTRL_JUMP = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                       idex_en: 1'b1, idex_flush: 1'b1,
                                       exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1};
   // Load-use: hold PC and IF_ID, inject a bubble into ID_EX.
   localparam hzd_ctrl_t CTRL_LOADUSE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                          idex_en: 1'b1, idex_flush: 1'b1,
                                          exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1};
   localparam hzd_ctrl_t CTRL_IMISS = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1,
                                        idex_en: 1'b1, idex_flush: 1'b0,
                                        exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1};
   localparam hzd_ctrl_t CTRL_HALTING = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                          idex_en: 1'b0, idex_flush: 1'b0,
                                          exmem_en: 1'b0, exmem_flush: 1'b0, memwb_en: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: one-cycle update on inc, sticks at all-ones, no backpressure.
// Synchronous active-high reset to zero.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch/PC sequencer: combinational enables/flushes from state and hazards, zero latency.
// Data-memory misses freeze the whole pipe (DWAIT) until dhit; HALT holds until RST.
module pipeline_hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int REG_W = $bits(regbits_t),
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic [REG_W-1:0] rs_id,
   input  logic [REG_W-1:0] rt_id,
   input  logic             dREN_ex,
   input  logic             RegWr_ex,
   input  logic [REG_W-1:0] wsel_ex,
   input  logic             jumpFlush_ex,
   input  logic             brTaken_mem,
   input  logic             dREN_mem,
   input  logic             dWEN_mem,
   input  logic             halt_wb,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             exmem_flush,
   output logic             memwb_en,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   hzd_state_t state_q, state_d;
   logic       halted_q, halted_d;
   logic       live_q, live_d;
   logic       lu_q, lu_d;
   hzd_ctrl_t  ctrl;
   logic       stall_inc;
   logic       dmiss;
   logic       load_use;
   logic       active;

   assign dmiss    = (dREN_mem | dWEN_mem) & ~dhit;
   assign load_use = dREN_ex & RegWr_ex & (wsel_ex != '0) &
                     ((wsel_ex == rs_id) | (wsel_ex == rt_id));
   // live_q keeps outputs quiet until the first edge after reset is released.
   assign active   = live_q & (state_q != HZ_HALT);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= HZ_RUN;
         halted_q <= 1'b0;
         live_q   <= 1'b0;
         lu_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
         live_q   <= live_d;
         lu_q     <= lu_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      halted_d = halted_q;
      live_d   = 1'b1;
      if (active) begin
         if (halt_wb) begin
            state_d  = HZ_HALT;
            halted_d = 1'b1;
         end else if (dmiss) begin
            state_d = HZ_DWAIT;
         end else begin
            state_d = HZ_RUN;
         end
      end
   end

   // lu_q marks a bubble already injected, so a stale hazard cannot stall twice.
   always_comb begin
      ctrl      = CTRL_IDLE;
      lu_d      = 1'b0;
      stall_inc = 1'b0;
      if (active) begin
         if (halt_wb) begin
            ctrl = CTRL_HALTING;
         end else if (dmiss) begin
            ctrl = CTRL_IDLE;
         end else if (brTaken_mem) begin
            ctrl = CTRL_BRANCH;
         end else if (jumpFlush_ex) begin
            ctrl = CTRL_JUMP;
         end else if (load_use && !lu_q) begin
            ctrl = CTRL_LOADUSE;
            lu_d = 1'b1;
         end else if (!ihit) begin
            ctrl = CTRL_IMISS;
         end else begin
            ctrl = CTRL_RUN;
         end
         stall_inc = ~ctrl.pc_en;
      end
   end

   assign pc_en       = ctrl.pc_en;
   assign ifid_en     = ctrl.ifid_en;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_en     = ctrl.idex_en;
   assign idex_flush  = ctrl.idex_flush;
   assign exmem_en    = ctrl.exmem_en;
   assign exmem_flush = ctrl.exmem_flush;
   assign memwb_en    = ctrl.memwb_en;
   assign halted      = halted_q;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector bench for pipeline_hazard_ctrl: table of per-cycle inputs with expected
// output bundle {pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,exmem_fl,memwb,halted} and stall_cnt.
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 32;

   localparam logic [8:0] O_IDLE   = 9'b000000000;
   localparam logic [8:0] O_RUN    = 9'b110101010;
   localparam logic [8:0] O_LU     = 9'b000111010;
   localparam logic [8:0] O_BR     = 9'b111111110;
   localparam logic [8:0] O_JUMP   = 9'b111111010;
   localparam logic [8:0] O_IMISS  = 9'b011101010;
   localparam logic [8:0] O_HALTC  = 9'b000000010;
   localparam logic [8:0] O_HALTED = 9'b000000001;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic ihit, dhit, dREN_ex, RegWr_ex, jumpFlush_ex, brTaken_mem, dREN_mem, dWEN_mem, halt_wb;
   logic [4:0] rs_id, rt_id, wsel_ex;
   logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, halted;
   logic [CNT_W-1:0] stall_cnt;

   typedef struct {
      string      name;
      logic       ih, dh;
      logic [4:0] rs, rt;
      logic       dre, rw;
      logic [4:0] ws;
      logic       jf, bt, drm, dwm, hw;
      logic [8:0] exp;
      logic [CNT_W-1:0] cnt;
   } vec_t;

   vec_t vt[$];
   int total = 0;
   int bad = 0;

   always #5 CLK = ~CLK;

   pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .rs_id(rs_id), .rt_id(rt_id),
      .dREN_ex(dREN_ex), .RegWr_ex(RegWr_ex), .wsel_ex(wsel_ex), .jumpFlush_ex(jumpFlush_ex),
      .brTaken_mem(brTaken_mem), .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .halt_wb(halt_wb),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
      .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
      .memwb_en(memwb_en), .halted(halted), .stall_cnt(stall_cnt)
   );

   function automatic vec_t mk(string n, bit ih, bit dh, int rs, int rt, bit dre, bit rw, int ws,
                               bit jf, bit bt, bit drm, bit dwm, bit hw,
                               logic [8:0] e, logic [CNT_W-1:0] c);
      vec_t v;
      v.name = n; v.ih = ih; v.dh = dh; v.rs = 5'(rs); v.rt = 5'(rt);
      v.dre = dre; v.rw = rw; v.ws = 5'(ws);
      v.jf = jf; v.bt = bt; v.drm = drm; v.dwm = dwm; v.hw = hw;
      v.exp = e; v.cnt = c;
      return v;
   endfunction

   function automatic logic [8:0] outs();
      return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
              memwb_en, halted};
   endfunction

   task automatic drive(vec_t v);
      ihit = v.ih; dhit = v.dh; rs_id = v.rs; rt_id = v.rt;
      dREN_ex = v.dre; RegWr_ex = v.rw; wsel_ex = v.ws;
      jumpFlush_ex = v.jf; brTaken_mem = v.bt; dREN_mem = v.drm; dWEN_mem = v.dwm;
      halt_wb = v.hw;
   endtask

   task automatic check_outs(string nm, logic [8:0] e);
      logic [8:0] got;
      got = outs();
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL %s: outputs got %b want %b", nm, got, e);
      end
   endtask

   task automatic check_cnt(string nm, logic [CNT_W-1:0] e);
      total++;
      if (stall_cnt !== e) begin
         bad++;
         $display("FAIL %s: stall_cnt got %0h want %0h", nm, stall_cnt, e);
      end
   endtask

   task automatic apply(vec_t v);
      @(negedge CLK);
      drive(v);
      #2;
      check_outs(v.name, v.exp);
      check_cnt(v.name, v.cnt);
   endtask

   // Holds RST for n edges, checking reset outputs, then releases it and checks the
   // quiet half-cycle before the first edge with RST low.
   task automatic do_reset(int n, string nm);
      @(negedge CLK);
      RST = 1'b1;
      drive(mk("idle", 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0));
      repeat (n) begin
         @(negedge CLK);
         #2;
         check_outs({nm, "_held"}, O_IDLE);
         check_cnt({nm, "_held"}, '0);
      end
      @(negedge CLK);
      RST = 1'b0;
      #2;
      check_outs({nm, "_release"}, O_IDLE);
      check_cnt({nm, "_release"}, '0);
   endtask

   initial begin
      drive(mk("idle", 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0));

      vt.push_back(mk("run0",       1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,   0));
      vt.push_back(mk("nomatch",    1, 1, 3, 7, 1, 1, 5, 0, 0, 0, 0, 0, O_RUN,   0));
      vt.push_back(mk("lu_rs",      1, 1, 5, 7, 1, 1, 5, 0, 0, 0, 0, 0, O_LU,    0));
      vt.push_back(mk("lu_held",    1, 1, 5, 7, 1, 1, 5, 0, 0, 0, 0, 0, O_RUN,   1));
      vt.push_back(mk("lu_rt",      1, 1, 1, 9, 1, 1, 9, 0, 0, 0, 0, 0, O_LU,    1));
      vt.push_back(mk("lu_r0",      1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, O_RUN,   2));
      vt.push_back(mk("lu_nowr",    1, 1, 5, 5, 1, 0, 5, 0, 0, 0, 0, 0, O_RUN,   2));
      vt.push_back(mk("jump",       1, 1, 5, 7, 0, 0, 0, 1, 0, 0, 0, 0, O_JUMP,  2));
      vt.push_back(mk("br_lu",      1, 1, 5, 7, 1, 1, 5, 0, 1, 0, 0, 0, O_BR,    2));
      vt.push_back(mk("br_jump",    1, 1, 1, 2, 0, 0, 0, 1, 1, 0, 0, 0, O_BR,    2));
      vt.push_back(mk("imiss",      0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, O_IMISS, 2));
      vt.push_back(mk("imiss_jump", 0, 1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, O_JUMP,  3));
      vt.push_back(mk("lu_imiss",   0, 1, 5, 7, 1, 1, 5, 0, 0, 0, 0, 0, O_LU,    3));
      vt.push_back(mk("run1",       1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,   4));
      vt.push_back(mk("dwen_hit",   1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, O_RUN,   4));
      for (int i = 0; i < 4; i++)
         vt.push_back(mk("dmiss_br", 1, 0, 1, 2, 0, 0, 0, 0, 1, 1, 0, 0, O_IDLE, 4 + i));
      vt.push_back(mk("dren_hit",   1, 1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, O_RUN,   8));
      vt.push_back(mk("run2",       1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,   8));
      vt.push_back(mk("dwen_miss",  1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, O_IDLE,  8));
      vt.push_back(mk("dhit_jump",  1, 1, 1, 2, 0, 0, 0, 1, 0, 0, 1, 0, O_JUMP,  9));
      vt.push_back(mk("run3",       1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,   9));

      do_reset(3, "rst0");
      foreach (vt[i]) apply(vt[i]);

      // Halt beats a pending miss and branch; the halt cycle itself is a stall in RUN.
      apply(mk("halt", 1, 0, 5, 7, 1, 1, 5, 1, 1, 1, 0, 1, O_HALTC, 9));
      for (int i = 0; i < 10; i++)
         apply(mk("halted", i[0], 0, 5, 7, 1, 1, 5, 0, i[0], 1, 0, 0, O_HALTED, 10));

      do_reset(1, "rst_halt");
      apply(mk("after_halt", 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0));

      // A load-use bubble in flight must not survive a reset.
      apply(mk("lu_pre_rst", 1, 1, 5, 7, 1, 1, 5, 0, 0, 0, 0, 0, O_LU, 0));
      do_reset(1, "rst_lu");
      apply(mk("lu_post_rst", 1, 1, 5, 7, 1, 1, 5, 0, 0, 0, 0, 0, O_LU, 0));

      apply(mk("dwait_pre_rst", 1, 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, O_IDLE, 1));
      do_reset(1, "rst_dwait");
      apply(mk("after_dwait", 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0));

      // Saturation: preload all-ones, then stall once more.
      @(negedge CLK);
      force dut.u_stall_cnt.count_q = {CNT_W{1'b1}};
      #1;
      release dut.u_stall_cnt.count_q;
      apply(mk("sat_stall", 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, O_IMISS, {CNT_W{1'b1}}));
      apply(mk("sat_hold", 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, O_IMISS, {CNT_W{1'b1}}));
      apply(mk("sat_after", 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, {CNT_W{1'b1}}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
